inst_fetch_unit: RTL and testbench

//   Fetch stage feeding the instruction decoder/controller. Holds the PC and

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_buffer.sv | 67 ++++++
 rtl/inst_fetch_unit.sv | 138 +++++++++++++
 tb/tb_inst_fetch_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: fetch FSM states and instruction constants.
package fetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_INC   = 32'd4;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO with push/pop/flush. Used for returned {inst, pc} words and
// for the PCs of requests still in flight to instruction memory.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] entry0_q, entry0_d;
  logic [WIDTH-1:0] entry1_q, entry1_d;
  logic [1:0]       count_q, count_d;

  // Entry 0 is always the head; entries shift forward on pop, flush wins over everything.
  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else if (push && pop && count_q != 2'd0) begin
      if (count_q == 2'd2) begin
        entry0_d = entry1_q;
        entry1_d = din;
      end else begin
        entry0_d = din;
      end
    end else if (pop) begin
      if (count_q != 2'd0) begin
        entry0_d = entry1_q;
        count_d  = count_q - 2'd1;
      end
    end else if (push && count_q != 2'd2) begin
      if (count_q == 2'd0) begin
        entry0_d = din;
      end else begin
        entry1_d = din;
      end
      count_d = count_q + 2'd1;
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
    end
  end

  assign head  = entry0_q;
  assign count = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, issues imem requests under a credit limit,
// buffers returned words with their PCs and redirects on taken branches,
// draining responses that belong to the abandoned path.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MAX_OUTST = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic        o_imem_req_vld,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_req_rdy,
  input  logic        i_imem_rsp_vld,
  input  logic [31:0] i_imem_rsp_data,
  output logic        o_inst_vld,
  input  logic        i_inst_rdy,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_four,
  input  logic        i_pc_sel,
  input  logic [31:0] i_alu_data,
  output logic        o_misalign
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [1:0]   outst_q, outst_d;
  logic [1:0]   stale_q, stale_d;
  logic         misalign_q, misalign_d;

  logic [1:0]   buf_cnt;
  logic [1:0]   pc_cnt;
  logic [63:0]  buf_head;
  logic [31:0]  pc_head;
  logic [2:0]   credit_used;
  logic         issue;
  logic         rsp_ok;
  logic         accept;
  logic         redirect;
  logic         buf_push;

  // Handshake decode; request valid is held low while reset is asserted.
  always_comb begin
    credit_used    = {1'b0, outst_q} + {1'b0, buf_cnt};
    o_imem_req_vld = !i_reset && (state_q == FETCH) && (credit_used < 3'(MAX_OUTST));
    issue          = o_imem_req_vld && i_imem_req_rdy;
    rsp_ok         = i_imem_rsp_vld && (outst_q != 2'd0);
    accept         = o_inst_vld && i_inst_rdy;
    redirect       = accept && i_pc_sel;
  end

  // Next PC, credit/stale counters and FSM; the redirect cycle's traffic is old-path.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    stale_d    = stale_q;
    misalign_d = 1'b0;
    buf_push   = 1'b0;
    outst_d    = outst_q + {1'b0, issue} - {1'b0, rsp_ok};
    if (issue) begin
      fetch_pc_d = fetch_pc_q + PC_INC;
    end
    if (rsp_ok) begin
      if (stale_q != 2'd0) begin
        stale_d = stale_q - 2'd1;
      end else if (state_q == FETCH && !redirect) begin
        buf_push = 1'b1;
      end
    end
    if (state_q == FETCH) begin
      if (redirect) begin
        fetch_pc_d = align_word(i_alu_data);
        stale_d    = outst_d;
        misalign_d = |i_alu_data[1:0];
        state_d    = (outst_d != 2'd0) ? DRAIN : FETCH;
      end
    end else begin
      if (stale_d == 2'd0) begin
        state_d = FETCH;
      end
    end
  end

  // State registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      outst_q    <= 2'd0;
      stale_q    <= 2'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      stale_q    <= stale_d;
      misalign_q <= misalign_d;
    end
  end

  fetch_buffer #(.WIDTH(32)) u_pc_fifo (
    .clk   (i_clk),
    .rst   (i_reset),
    .push  (issue),
    .pop   (rsp_ok),
    .flush (1'b0),
    .din   (fetch_pc_q),
    .head  (pc_head),
    .count (pc_cnt)
  );

  fetch_buffer #(.WIDTH(64)) u_inst_buf (
    .clk   (i_clk),
    .rst   (i_reset),
    .push  (buf_push),
    .pop   (accept),
    .flush (redirect),
    .din   ({i_imem_rsp_data, pc_head}),
    .head  (buf_head),
    .count (buf_cnt)
  );

  assign o_imem_addr = fetch_pc_q;
  assign o_inst_vld  = (buf_cnt != 2'd0);
  assign o_inst      = o_inst_vld ? buf_head[63:32] : INST_NOP;
  assign o_pc        = o_inst_vld ? buf_head[31:0] : RESET_PC;
  assign o_pc_four   = o_pc + PC_INC;
  assign o_misalign  = misalign_q;

  // Credits cover buffered words, so a kept response never lands on a full buffer.
  assert property (@(posedge i_clk) disable iff (i_reset) !(buf_push && buf_cnt == 2'd2));

  // The in-flight PC FIFO tracks the outstanding counter exactly.
  assert property (@(posedge i_clk) disable iff (i_reset) pc_cnt == outst_q);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized bench for inst_fetch_unit: an in-order imem model with random
// latency, a random decoder, and a program-order reference for PCs/words.
module tb_inst_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        i_clk;
  logic        i_reset;
  logic        o_imem_req_vld;
  logic [31:0] o_imem_addr;
  logic        i_imem_req_rdy;
  logic        i_imem_rsp_vld;
  logic [31:0] i_imem_rsp_data;
  logic        o_inst_vld;
  logic        i_inst_rdy;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic [31:0] o_pc_four;
  logic        i_pc_sel;
  logic [31:0] i_alu_data;
  logic        o_misalign;

  inst_fetch_unit #(.RESET_PC(RST_PC), .MAX_OUTST(2)) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .o_imem_req_vld  (o_imem_req_vld),
    .o_imem_addr     (o_imem_addr),
    .i_imem_req_rdy  (i_imem_req_rdy),
    .i_imem_rsp_vld  (i_imem_rsp_vld),
    .i_imem_rsp_data (i_imem_rsp_data),
    .o_inst_vld      (o_inst_vld),
    .i_inst_rdy      (i_inst_rdy),
    .o_inst          (o_inst),
    .o_pc            (o_pc),
    .o_pc_four       (o_pc_four),
    .i_pc_sel        (i_pc_sel),
    .i_alu_data      (i_alu_data),
    .o_misalign      (o_misalign)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] addr;
    int          ready_cyc;
    int          epoch;
  } req_t;

  req_t        imem_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          accepts = 0;
  int          req_fires = 0;
  logic [31:0] next_req_addr;
  logic [31:0] exp_pc;
  bit          misalign_pending;
  int          knob_req_rdy;
  int          knob_inst_rdy;
  int          knob_rsp;
  bit          knob_redirect;

  // Contents of instruction memory at a given address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic checkWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    checkBit({tag, "_req_vld"}, o_imem_req_vld, 1'b0);
    checkBit({tag, "_inst_vld"}, o_inst_vld, 1'b0);
    checkBit({tag, "_misalign"}, o_misalign, 1'b0);
    checkWord({tag, "_inst"}, o_inst, NOP);
    checkWord({tag, "_pc"}, o_pc, RST_PC);
    checkWord({tag, "_pc_four"}, o_pc_four, 32'hFFFF_FFFC);
  endtask

  task automatic resetModel();
    imem_q.delete();
    next_req_addr    = RST_PC;
    exp_pc           = RST_PC;
    epoch            = 0;
    misalign_pending = 1'b0;
  endtask

  // Drive one cycle's inputs according to the current knobs.
  task automatic applyStimulus();
    i_imem_req_rdy  = (knob_req_rdy == 2) ? ($urandom_range(0, 3) != 0) : (knob_req_rdy == 1);
    i_inst_rdy      = (knob_inst_rdy == 2) ? ($urandom_range(0, 2) != 0) : (knob_inst_rdy == 1);
    i_pc_sel        = knob_redirect && ($urandom_range(0, 5) == 0);
    i_alu_data      = $urandom();
    i_imem_rsp_vld  = 1'b0;
    i_imem_rsp_data = $urandom();
    if (imem_q.size() > 0 && knob_rsp != 0) begin
      if (imem_q[0].ready_cyc <= cyc && (knob_rsp == 1 || $urandom_range(0, 2) != 0)) begin
        i_imem_rsp_vld  = 1'b1;
        i_imem_rsp_data = memWord(imem_q[0].addr);
      end
    end
  endtask

  // Compare this cycle's handshakes against the program-order reference and advance it.
  task automatic checkOutput();
    int old_left;
    checkBit("misalign", o_misalign, misalign_pending);
    misalign_pending = 1'b0;
    if (o_imem_req_vld && i_imem_req_rdy) begin
      req_fires++;
      checkWord("req_addr", o_imem_addr, next_req_addr);
      old_left = 0;
      foreach (imem_q[i]) if (imem_q[i].epoch != epoch) old_left++;
      checkWord("drain_before_new_req", 32'(old_left), 32'd0);
      imem_q.push_back('{addr: o_imem_addr, ready_cyc: cyc + 1 + int'($urandom_range(0, 2)), epoch: epoch});
      checkBit("credit_limit", imem_q.size() <= 2, 1'b1);
      next_req_addr = next_req_addr + 32'd4;
    end
    if (i_imem_rsp_vld) void'(imem_q.pop_front());
    if (o_inst_vld && i_inst_rdy) begin
      accepts++;
      checkWord("o_pc", o_pc, exp_pc);
      checkWord("o_inst", o_inst, memWord(exp_pc));
      checkWord("o_pc_four", o_pc_four, exp_pc + 32'd4);
      if (i_pc_sel) begin
        exp_pc           = {i_alu_data[31:2], 2'b00};
        next_req_addr    = exp_pc;
        epoch++;
        misalign_pending = (i_alu_data[1:0] != 2'b00);
      end else begin
        exp_pc = exp_pc + 32'd4;
      end
    end
  endtask

  task automatic stepCycle();
    applyStimulus();
    #1;
    checkOutput();
    @(posedge i_clk);
    cyc++;
    @(negedge i_clk);
  endtask

  initial begin
    i_reset         = 1'b1;
    i_imem_req_rdy  = 1'b0;
    i_imem_rsp_vld  = 1'b0;
    i_imem_rsp_data = 32'd0;
    i_inst_rdy      = 1'b0;
    i_pc_sel        = 1'b0;
    i_alu_data      = 32'd0;
    resetModel();
    repeat (2) @(negedge i_clk);
    checkReset("por");

    // Decoder stalled: credits allow exactly two requests, then issue stops.
    knob_req_rdy  = 1;
    knob_inst_rdy = 0;
    knob_rsp      = 1;
    knob_redirect = 1'b0;
    i_reset       = 1'b0;
    req_fires     = 0;
    repeat (8) stepCycle();
    checkWord("stall_req_count", 32'(req_fires), 32'd2);
    checkBit("stall_req_vld", o_imem_req_vld, 1'b0);
    checkBit("stall_inst_vld", o_inst_vld, 1'b1);

    // Random traffic with redirects; the first addresses wrap through zero.
    knob_req_rdy  = 2;
    knob_inst_rdy = 2;
    knob_rsp      = 2;
    knob_redirect = 1'b1;
    repeat (300) stepCycle();

    // Build up requests in flight with responses withheld.
    knob_req_rdy  = 1;
    knob_inst_rdy = 1;
    knob_rsp      = 0;
    knob_redirect = 1'b0;
    repeat (6) stepCycle();

    // Asynchronous reset mid-operation, late responses keep arriving.
    i_reset = 1'b1;
    #1;
    checkReset("mid_reset");
    if (imem_q.size() > 0) begin
      i_imem_rsp_vld  = 1'b1;
      i_imem_rsp_data = memWord(imem_q[0].addr);
      void'(imem_q.pop_front());
    end
    @(posedge i_clk);
    @(negedge i_clk);
    cyc++;
    checkReset("reset_hold");
    i_imem_rsp_vld = 1'b0;

    i_reset        = 1'b0;
    i_imem_req_rdy = 1'b0;
    i_inst_rdy     = 1'b0;
    if (imem_q.size() > 0) begin
      i_imem_rsp_vld  = 1'b1;
      i_imem_rsp_data = memWord(imem_q[0].addr);
    end
    resetModel();
    @(posedge i_clk);
    @(negedge i_clk);
    cyc++;
    i_imem_rsp_vld = 1'b0;
    checkBit("late_rsp_ignored", o_inst_vld, 1'b0);
    checkBit("req_after_reset", o_imem_req_vld, 1'b1);
    checkWord("addr_after_reset", o_imem_addr, RST_PC);

    knob_req_rdy  = 2;
    knob_inst_rdy = 2;
    knob_rsp      = 2;
    knob_redirect = 1'b1;
    repeat (300) stepCycle();
    checkBit("accept_activity", accepts > 30, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
